jtframe_i2s_rx: RTL

- I2S slave receiver: samples external BCLK/LRCK/DATA inside the system clock domain.
- Produces parallel signed left/right words and a one-cycle `sample` strobe per stereo pair.
- It is the receive-side counterpart of the board I2S DAC transmitter. Uses: audio loop-back checks, external ADC/codec input into cores, frame-level audio capture in simulation.
- Sits between the board I2S pins and game/frame logic; clocked by clk_sys.

---
 rtl/jtframe_i2s_pkg.sv | 27 ++
 rtl/jtframe_i2s_sync.sv | 39 +++
 rtl/jtframe_i2s_rx.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/jtframe_i2s_pkg.sv
// Shared definitions for the I2S receiver and the transmitter bench model.
package jtframe_i2s_pkg;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    // Width of the per-slot bit counter; the counter saturates at its top value.
    localparam int              CNTW    = 6;
    localparam logic [CNTW-1:0] CNT_MAX = 6'd63;

    typedef enum logic {
        HUNT = 1'b0,
        RX   = 1'b1
    } i2s_state_t;

    // Increment that sticks at CNT_MAX instead of wrapping.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        logic [CNTW-1:0] res;
        if (v == CNT_MAX) begin
            res = v;
        end else begin
            res = v + 6'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/jtframe_i2s_sync.sv
// Synchronizes BCLK/LRCK/DATA into the system clock domain and flags BCLK rising edges.
module jtframe_i2s_sync
    import jtframe_i2s_pkg::*;
#(
    parameter int SYNC = 2          // number of stages, at least 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_bclk,
    input  logic i_lrck,
    input  logic i_data,
    output logic o_bclk_rise,
    output logic o_lrck,
    output logic o_data
);

    // All three pins share one pipeline so they stay aligned to each other.
    logic [SYNC-1:0][2:0] r_pipe;
    logic                 r_bclk_prev;
    logic [2:0]           w_pins;

    assign w_pins = {i_bclk, i_lrck, i_data};

    // Multi-stage synchronizer plus a delayed copy of the synced bit clock.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pipe      <= '0;
            r_bclk_prev <= 1'b0;
        end else begin
            r_pipe      <= {r_pipe[SYNC-2:0], w_pins};
            r_bclk_prev <= r_pipe[SYNC-1][2];
        end
    end

    assign o_bclk_rise = r_pipe[SYNC-1][2] & ~r_bclk_prev;
    assign o_lrck      = r_pipe[SYNC-1][1];
    assign o_data      = r_pipe[SYNC-1][0];

endmodule

// File: rtl/jtframe_i2s_rx.sv
// I2S slave receiver: deserializes left/right words and strobes each complete stereo pair.
module jtframe_i2s_rx
    import jtframe_i2s_pkg::*;
#(
    parameter int DW   = 16,
    parameter int SYNC = 2,
    parameter int TOUT = 1023
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_i2s_bclk,
    input  logic            i_i2s_lrck,
    input  logic            i_i2s_data,
    output logic [DW-1:0]   o_snd_left,
    output logic [DW-1:0]   o_snd_right,
    output logic            o_sample,
    output logic            o_locked,
    output logic [CNTW-1:0] o_bits
);

    localparam logic [9:0] TOUT_C = 10'(TOUT);

    logic            w_bclk_rise;
    logic            w_lrck;
    logic            w_data;
    logic            w_tout;
    logic [DW-1:0]   w_word;
    logic [CNTW-1:0] w_len;

    i2s_state_t      r_state;
    logic [DW-1:0]   r_shreg;
    logic [CNTW-1:0] r_cnt;
    logic            r_chan;
    logic            r_last_lrck;
    logic            r_primed;
    logic [DW-1:0]   r_left_hold;
    logic            r_left_valid;
    logic [DW-1:0]   r_pend_right;
    logic            r_pend;
    logic [CNTW-1:0] r_bits;
    logic            r_locked;
    logic [9:0]      r_idle;
    logic [DW-1:0]   r_snd_left;
    logic [DW-1:0]   r_snd_right;
    logic            r_sample;

    jtframe_i2s_sync #(.SYNC(SYNC)) u_sync (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_bclk      (i_i2s_bclk),
        .i_lrck      (i_i2s_lrck),
        .i_data      (i_i2s_data),
        .o_bclk_rise (w_bclk_rise),
        .o_lrck      (w_lrck),
        .o_data      (w_data)
    );

    assign w_tout = (r_idle == TOUT_C);
    assign w_len  = sat_inc(r_cnt);

    // Current word with this edge's bit placed MSB-first; bits past DW fall off.
    always_comb begin
        w_word = r_shreg;
        for (int i = 0; i < DW; i++) begin
            if (int'(r_cnt) == DW - 1 - i) begin
                w_word[i] = w_data;
            end else begin
                w_word[i] = r_shreg[i];
            end
        end
    end

    // Counts clk cycles since the last BCLK rising edge, sticking at the timeout value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idle <= 10'd0;
        end else if (w_bclk_rise) begin
            r_idle <= 10'd0;
        end else if (!w_tout) begin
            r_idle <= r_idle + 10'd1;
        end
    end

    // Framing FSM: hunts for an LRCK edge, then shifts words and commits them at each boundary.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= HUNT;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_chan       <= LEFT;
            r_last_lrck  <= 1'b0;
            r_primed     <= 1'b0;
            r_left_hold  <= '0;
            r_left_valid <= 1'b0;
            r_pend_right <= '0;
            r_pend       <= 1'b0;
            r_bits       <= '0;
            r_locked     <= 1'b0;
        end else if (w_tout) begin
            // Link lost: drop partial data and any half pair, keep last output words.
            r_state      <= HUNT;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_left_valid <= 1'b0;
            r_pend       <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_pend <= 1'b0;
            if (w_bclk_rise) begin
                r_last_lrck <= w_lrck;
                r_primed    <= 1'b1;
                case (r_state)
                    HUNT: begin
                        // The first edge after reset only establishes the LRCK reference.
                        if (r_primed && (w_lrck != r_last_lrck)) begin
                            r_shreg <= '0;
                            r_cnt   <= '0;
                            r_chan  <= w_lrck;
                            r_state <= RX;
                        end
                    end
                    RX: begin
                        if (w_lrck == r_chan) begin
                            r_shreg <= w_word;
                            r_cnt   <= sat_inc(r_cnt);
                        end else begin
                            // Boundary: this edge carries the LSB slot of the finished word.
                            r_bits <= w_len;
                            if (w_len != r_bits) begin
                                r_locked <= 1'b0;
                            end else if (int'(w_len) >= DW) begin
                                r_locked <= 1'b1;
                            end
                            if (r_chan == LEFT) begin
                                r_left_hold  <= w_word;
                                r_left_valid <= 1'b1;
                            end else if (r_left_valid) begin
                                r_pend_right <= w_word;
                                r_pend       <= 1'b1;
                                r_left_valid <= 1'b0;
                            end
                            r_shreg <= '0;
                            r_cnt   <= '0;
                            r_chan  <= w_lrck;
                        end
                    end
                    default: begin
                        r_state <= HUNT;
                    end
                endcase
            end
        end
    end

    // Publishes a completed stereo pair together with a one-cycle strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_snd_left  <= '0;
            r_snd_right <= '0;
            r_sample    <= 1'b0;
        end else begin
            r_sample <= r_pend;
            if (r_pend) begin
                r_snd_left  <= r_left_hold;
                r_snd_right <= r_pend_right;
            end
        end
    end

    assign o_snd_left  = r_snd_left;
    assign o_snd_right = r_snd_right;
    assign o_sample    = r_sample;
    assign o_locked    = r_locked;
    assign o_bits      = r_bits;

endmodule
